// File: rtl/joypad_port.sv
// NES standard controller port: 2-flop synchronizer, sampled debouncer and
// 4021-style latch/shift register. Optional turbo A/B inputs under JOYPAD_TURBO_EN.
module joypad_port #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  TURBO_DIV       = 8'd4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clock_en,
    input  logic       latch,
    input  logic       pulse,
    input  logic [7:0] buttons_raw,
`ifdef JOYPAD_TURBO_EN
    input  logic       turbo_a,
    input  logic       turbo_b,
`endif
    output logic       ctlr_data,
    output logic [7:0] buttons_db
);

`ifdef JOYPAD_TURBO_EN
    localparam int NB = 10;
    logic [NB-1:0] raw_vec;
    assign raw_vec = {turbo_b, turbo_a, buttons_raw};
`else
    localparam int NB = 8;
    logic [NB-1:0] raw_vec;
    assign raw_vec = buttons_raw;
`endif

    logic [NB-1:0] sync1_reg;
    logic [NB-1:0] sync2_reg;
    logic [15:0]   sample_cnt_reg;
    logic [15:0]   sample_cnt_next;
    logic          sample_wrap;
    logic [NB-1:0] prev_sample_reg;
    logic [NB-1:0] db_reg;
    logic [NB-1:0] db_next;
    logic [7:0]    eff_buttons;
    logic [7:0]    shreg_reg;
    logic [7:0]    shreg_next;

    // Free-running synchronizer, independent of the CPU clock enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_vec;
            sync2_reg <= sync1_reg;
        end
    end

    assign sample_wrap     = (sample_cnt_reg == DEBOUNCE_CYCLES - 16'd1);
    assign sample_cnt_next = sample_wrap ? 16'd0 : sample_cnt_reg + 16'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_cnt_reg  <= 16'd0;
            prev_sample_reg <= '0;
        end else begin
            sample_cnt_reg <= sample_cnt_next;
            if (sample_wrap) begin
                prev_sample_reg <= sync2_reg;
            end
        end
    end

    // A bit is accepted only when two consecutive samples agree.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_debounce
            assign db_next[gi] = (sample_wrap && (sync2_reg[gi] == prev_sample_reg[gi]))
                                 ? sync2_reg[gi] : db_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_reg <= '0;
        end else begin
            db_reg <= db_next;
        end
    end

    assign buttons_db = db_reg[7:0];

`ifdef JOYPAD_TURBO_EN
    logic [7:0] turbo_cnt_reg;
    logic       phase_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            turbo_cnt_reg <= 8'd0;
            phase_reg     <= 1'b0;
        end else if (clock_en) begin
            if (turbo_cnt_reg == TURBO_DIV - 8'd1) begin
                turbo_cnt_reg <= 8'd0;
                phase_reg     <= ~phase_reg;
            end else begin
                turbo_cnt_reg <= turbo_cnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        eff_buttons    = db_reg[7:0];
        eff_buttons[0] = db_reg[0] | (db_reg[8] & phase_reg);
        eff_buttons[1] = db_reg[1] | (db_reg[9] & phase_reg);
    end
`else
    // TURBO_DIV only matters in the turbo build; keep it referenced here.
    if (TURBO_DIV == 8'd0) begin : g_turbo_div_unused
    end

    assign eff_buttons = db_reg[7:0];
`endif

    // Latch has priority over pulse; a 1 is shifted in so past-end bits read as 1 at the CPU.
    always_comb begin
        shreg_next = shreg_reg;
        if (clock_en) begin
            if (latch) begin
                shreg_next = eff_buttons;
            end else if (pulse) begin
                shreg_next = {1'b1, shreg_reg[7:1]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_reg <= 8'h00;
        end else begin
            shreg_reg <= shreg_next;
        end
    end

    assign ctlr_data = ~shreg_reg[0];

endmodule
